// File: rtl/config_chain_loader_pkg.sv
// Shared types for the configuration chain loader: sequencer states and defaults.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } cfg_state_t;

  localparam int CLR_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/config_chain_loader_piso.sv
// Parallel-load / serial-out shift register feeding the chain head, LSB first.
module cfg_piso #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] sr;

  // Zero fill on shift keeps the serial bit at 0 once a word is exhausted.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign lsb = sr[0];

endmodule

// File: rtl/config_chain_loader.sv
// Programs a PE configuration scan chain from a word stream and captures the
// old chain contents leaving the tail as readback words.
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN  = 12,
  parameter int WORD_W     = 32,
  parameter int CLR_CYCLES = CLR_CYCLES_DEFAULT,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              config_reset,
  output logic              config_shift,
  output logic              config_in,
  input  logic              config_out,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        state_dbg
);

  localparam int WB_W  = $clog2(WORD_W);
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  cfg_state_t        state_q, state_n;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WB_W-1:0]   wb_cnt;
  logic [CLR_W-1:0]  clr_cnt;
  logic [WORD_W-1:0] sipo, sipo_nxt;
  logic              kill, last_bit, word_end, accept;

  // word_valid/word_ready: a word transfers on a rising edge where both are
  // high; word_ready is raised only in LOAD and never depends on word_valid.
  assign kill     = abort && (state_q != ST_IDLE);
  assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign word_end = (wb_cnt == WB_W'(WORD_W - 1));
  assign accept   = (state_q == ST_LOAD) && word_valid;

  assign state_dbg = state_q;

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_n = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_n = ST_LOAD;
      ST_LOAD:  if (word_valid) state_n = ST_SHIFT;
      ST_SHIFT: begin
        if (last_bit) state_n = ST_DONE;
        else if (word_end) state_n = ST_LOAD;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    if (abort) state_n = ST_IDLE;
  end

  always_comb begin
    sipo_nxt         = sipo;
    sipo_nxt[wb_cnt] = config_out;
  end

  cfg_piso #(.WIDTH(WORD_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .clr   (state_n != ST_SHIFT),
    .load  (accept && !kill),
    .shift (state_q == ST_SHIFT),
    .din   (word_data),
    .lsb   (config_in)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_ready   <= 1'b0;
      config_reset <= 1'b0;
      config_shift <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      rb_valid     <= 1'b0;
      rb_data      <= '0;
      sipo         <= '0;
      bit_cnt      <= '0;
      wb_cnt       <= '0;
      clr_cnt      <= '0;
    end else begin
      state_q      <= state_n;
      word_ready   <= (state_n == ST_LOAD);
      config_reset <= (state_n == ST_CLEAR);
      config_shift <= (state_n == ST_SHIFT);
      busy         <= (state_n != ST_IDLE);
      done         <= (state_n == ST_DONE);
      aborted      <= kill;
      rb_valid     <= (state_q == ST_SHIFT) && !kill && (word_end || last_bit);
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            bit_cnt <= '0;
            wb_cnt  <= '0;
            clr_cnt <= '0;
            sipo    <= '0;
          end
        end
        ST_CLEAR: clr_cnt <= clr_cnt + 1'b1;
        ST_SHIFT: begin
          if (bit_cnt != CNT_W'(CHAIN_LEN)) bit_cnt <= bit_cnt + 1'b1;
          wb_cnt <= word_end ? '0 : wb_cnt + 1'b1;
          // A finished or truncated word leaves through rb_data; the cleared
          // SIPO makes a final partial word come out zero-extended.
          if (word_end || last_bit) begin
            sipo <= '0;
            if (!kill) rb_data <= sipo_nxt;
          end else begin
            sipo <= sipo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
